// File: rtl/mem_if_pkg.sv
// mem_if_pkg: shared encodings for the CPU-side data-memory interface
package mem_if_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] SIZE_BYTE = 3'b001;
    localparam logic [2:0] SIZE_HALF = 3'b011;
    localparam logic [2:0] SIZE_WORD = 3'b111;
    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;
endpackage

// File: rtl/lsu_req_decode.sv
// lsu_req_decode: funct3/write/addr[1:0] -> sign_mask, illegal, misaligned
//   in:  funct3, write, addr_lo   out: sign_mask, illegal, misaligned
module lsu_req_decode
    import mem_if_pkg::*;
#(
    parameter int ALIGN_CHECK = 1
) (
    input  logic [2:0] funct3,
    input  logic       write,
    input  logic [1:0] addr_lo,
    output logic [3:0] sign_mask,
    output logic       illegal,
    output logic       misaligned
);
    logic [2:0] size;
    always_comb begin
        size = funct3[1:0] == 2'b00 ? SIZE_BYTE :
               funct3[1:0] == 2'b01 ? SIZE_HALF :
               funct3[1:0] == 2'b10 ? SIZE_WORD : 3'b000;
        // full-width words carry no sign bit, so LW is always 0111
        sign_mask  = {~funct3[2] & ~write & (size != SIZE_WORD), size};
        illegal    = (funct3[1:0] == 2'b11) | (write & funct3[2]) | (funct3 == 3'b110);
        misaligned = (ALIGN_CHECK != 0) &&
                     ((size == SIZE_HALF && addr_lo[0]) || (size == SIZE_WORD && addr_lo != 2'b00));
    end
endmodule

// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator: load/store initiator driving a clk_stall-handshaked data memory
//   req_*  : pipeline request (valid/ready), resp_* : one registered response per request
//   mem_*  : strobe/addr/data/sign_mask to responder, read_data/clk_stall back
//   busy   : high whenever not IDLE
module lsu_mem_initiator
    import mem_if_pkg::*;
#(
    parameter int TIMEOUT     = 16,
    parameter int ALIGN_CHECK = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [1:0]  resp_err_code,
    output logic        busy,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_memread,
    output logic        mem_memwrite,
    output logic [3:0]  mem_sign_mask,
    input  logic [31:0] mem_read_data,
    input  logic        mem_clk_stall
);
    localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);
    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic        wr, wr_n;
    logic [31:0] addr_n, wdata_n, rdata_n;
    logic [3:0]  mask_n, dec_mask;
    logic        rd_n, wt_n, rv_n, err_n, illegal, misaligned, accept;
    logic [1:0]  code_n;
    lsu_req_decode #(.ALIGN_CHECK(ALIGN_CHECK)) u_dec (
        .funct3    (req_funct3),
        .write     (req_write),
        .addr_lo   (req_addr[1:0]),
        .sign_mask (dec_mask),
        .illegal   (illegal),
        .misaligned(misaligned)
    );
    // the responder has no reset, so a stall left over from before reset must block new requests
    assign req_ready = (state == IDLE) & ~mem_clk_stall;
    assign busy      = state != IDLE;
    assign accept    = req_valid & req_ready;
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        wr_n    = wr;
        addr_n  = mem_addr;
        wdata_n = mem_write_data;
        mask_n  = mem_sign_mask;
        rd_n    = 1'b0;
        wt_n    = 1'b0;
        rv_n    = 1'b0;
        rdata_n = 32'd0;
        err_n   = 1'b0;
        code_n  = ERR_NONE;
        case (state)
            IDLE: if (accept) begin
                if (illegal | misaligned) begin
                    rv_n   = 1'b1;
                    err_n  = 1'b1;
                    code_n = illegal ? ERR_ILLEGAL : ERR_MISALIGN;
                end else begin
                    addr_n  = req_addr;
                    wdata_n = req_wdata;
                    mask_n  = dec_mask;
                    wr_n    = req_write;
                    rd_n    = ~req_write;
                    wt_n    = req_write;
                    state_n = ISSUE;
                end
            end
            // strobe lives exactly one cycle; a held strobe would retrigger the responder
            ISSUE: begin
                cnt_n   = 8'd0;
                state_n = WAIT_ACK;
            end
            WAIT_ACK, WAIT_DONE: begin
                if (state == WAIT_ACK && mem_clk_stall) begin
                    cnt_n   = 8'd0;
                    state_n = WAIT_DONE;
                end else if (state == WAIT_DONE && !mem_clk_stall) begin
                    rv_n    = 1'b1;
                    rdata_n = wr ? 32'd0 : mem_read_data;
                    state_n = IDLE;
                end else if (cnt == TMAX) begin
                    rv_n    = 1'b1;
                    err_n   = 1'b1;
                    code_n  = ERR_TIMEOUT;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt == 8'hFF ? cnt : cnt + 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= 8'd0;
            wr             <= 1'b0;
            mem_addr       <= 32'd0;
            mem_write_data <= 32'd0;
            mem_sign_mask  <= 4'd0;
            mem_memread    <= 1'b0;
            mem_memwrite   <= 1'b0;
            resp_valid     <= 1'b0;
            resp_rdata     <= 32'd0;
            resp_err       <= 1'b0;
            resp_err_code  <= ERR_NONE;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            wr             <= wr_n;
            mem_addr       <= addr_n;
            mem_write_data <= wdata_n;
            mem_sign_mask  <= mask_n;
            mem_memread    <= rd_n;
            mem_memwrite   <= wt_n;
            resp_valid     <= rv_n;
            resp_rdata     <= rdata_n;
            resp_err       <= err_n;
            resp_err_code  <= code_n;
        end
    end
endmodule

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
- Load/store initiator on the CPU side of the data-memory interface. Drives the memread/memwrite strobe, address, write data and sign_mask; follows the responder's clk_stall handshake; returns one response per request to the pipeline.
- Checks alignment and funct3 legality, and detects stalled-responder timeouts. Sits between the MEM-stage request/response interface and the data memory block.
- Performs no byte extraction or merging; the data memory block does that.

Parameters:
- TIMEOUT, 16, max cycles spent in either wait state before aborting with a timeout error (range 2..255).
- ALIGN_CHECK, 1, 1 = misaligned halfword/word requests are rejected; 0 = they are issued unchanged.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  pipeline request valid
- req_ready  out  1  request accepted when req_valid & req_ready at posedge clk
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, passed raw (responder places low byte/halfword)
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  load result; 0 for stores and errors
- resp_err  out  1  error flag, qualified by resp_valid
- resp_err_code  out  2  01 misaligned, 10 illegal funct3, 11 timeout, 00 none
- busy  out  1  high while not in IDLE (pipeline stall)
- mem_addr  out  32  to responder addr
- mem_write_data  out  32  to responder write_data
- mem_memread  out  1  read strobe
- mem_memwrite  out  1  write strobe
- mem_sign_mask  out  4  [3] sign-extend, [2:0] size: 001 byte, 011 half, 111 word
- mem_read_data  in  32  responder read_data
- mem_clk_stall  in  1  responder clk_stall

Behaviour:
- Reset: all state returns to IDLE; all outputs go to 0; req_ready follows its IDLE rule.
- All outputs are registered except req_ready and busy.
- req_ready = (state==IDLE) & ~mem_clk_stall. Because the responder has no reset, reset can arrive mid-transaction. A new request is then blocked until the responder's clk_stall drops.
- sign_mask encoding:
  - Size bits from funct3[1:0]: 00→001, 01→011, 10→111.
  - Bit [3] = ~funct3[2] & ~req_write.
  - LW is always sent as 0111.
- Illegal combinations, rejected with code 10: funct3[1:0]==11; stores with funct3[2]=1; funct3 110.
- Misaligned (ALIGN_CHECK=1), rejected with code 01: halfword with addr[0]=1; word with addr[1:0]≠00.
- State machine:
  - IDLE:
    - Rejected request on accept edge: resp_valid=1 and resp_err=1 on the next cycle. No strobe is issued; state stays IDLE.
    - Legal request on accept edge: register addr, wdata and sign_mask; raise exactly one of mem_memread/mem_memwrite; go to ISSUE.
  - ISSUE: the strobe is high for exactly this one cycle. On the next edge, drop the strobe, clear the counter and go to WAIT_ACK. The strobe must never stay high for two cycles; the responder retriggers on a held strobe.
  - WAIT_ACK: wait for mem_clk_stall=1, then go to WAIT_DONE and clear the counter.
  - WAIT_DONE: wait for mem_clk_stall=0. Then capture mem_read_data (loads) or 0 (stores) into resp_rdata, pulse resp_valid for one cycle, and go to IDLE.
  - Timeout (either wait state): when the counter reaches TIMEOUT-1, pulse resp_valid with resp_err=1, code 11, and go to IDLE.
- Nominal latency: 4 edges from accept to the resp_valid edge, identical for loads and stores. Accept at E0; strobe visible during E0–E1; stall sampled high at E2; stall sampled low at E4; resp_valid is high during the cycle after E4.
- Back-to-back: the earliest next accept is the edge after resp_valid. The sustained rate is one access per 5 cycles.
- mem_addr, mem_write_data and mem_sign_mask hold their values from accept until the next accept.
- Counter width is 8 bits. It saturates and never wraps.

Decomposition:
- Shared package (mem_if_pkg):
  - funct3 constants
  - SIZE_BYTE/HALF/WORD sign_mask encodings
  - ERR_* codes
  - state encoding IDLE/ISSUE/WAIT_ACK/WAIT_DONE
- One natural sub-module: lsu_req_decode, a combinational block mapping funct3, req_write and addr[1:0] to sign_mask, illegal and misaligned. It is reusable by the instruction decoder.

Test Plan:
- LW addr 0x1004 against a responder model holding 0xDEADBEEF → mem_memread high for exactly 1 cycle, mem_sign_mask=0111; resp_valid 4 edges after accept; resp_rdata=0xDEADBEEF, resp_err=0.
- LB addr 0x1001 (responder returns 0xFFFFFFAB) → sign_mask=1001; LBU same address → sign_mask=0001; both pass the returned data through unchanged.
- SH addr 0x1003, wdata 0x1234 → no strobe issued; resp_valid on the next cycle with err=1, code 01. With ALIGN_CHECK=0 → mem_memwrite is issued with sign_mask=0011.
- funct3=011 load, then SB with funct3=100 → each gives an immediate error response with code 10; mem_memread and mem_memwrite stay 0.
- Responder holds clk_stall=0 forever after an SW → resp_err=1, code 11, at cycle TIMEOUT after the WAIT_ACK entry; busy drops; the next request is accepted.
- Assert reset during WAIT_DONE while the responder model keeps clk_stall=1 for 2 more cycles → outputs go to 0; req_ready stays 0 until clk_stall=0; a queued LW then completes normally.
